// File: rtl/memstage_ctrl.sv
// rtl/memstage_ctrl.sv - MEM-stage controller: data-memory handshake, branch resolution, MEM/WB register
module memstage_ctrl #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              memwrin,
    input  logic              memrdin,
    input  logic              bbnein,
    input  logic              bbeqin,
    input  logic              bblezin,
    input  logic              bbgtzin,
    input  logic              jumpin,
    input  logic [1:0]        memtoregin,
    input  logic              regwrin,
    input  logic              finin,
    input  logic [DWIDTH-1:0] aluoutin,
    input  logic              zeroin,
    input  logic              negativein,
    input  logic [4:0]        regdstmuxin,
    input  logic [DWIDTH-1:0] regdata2in,
    input  logic [AWIDTH-1:0] branaddrin,
    input  logic [AWIDTH-1:0] jmpaddrin,
    input  logic [AWIDTH-1:0] pcnextin,
    input  logic [31:0]       insin,
    output logic              dmemreq,
    output logic              dmemwe,
    output logic [AWIDTH-1:0] dmemaddr,
    output logic [DWIDTH-1:0] dmemwdata,
    input  logic [DWIDTH-1:0] dmemrdata,
    input  logic              dmemack,
    output logic              pcsrc,
    output logic [AWIDTH-1:0] pctarget,
    output logic              flushout,
    output logic              stall,
    output logic              memerr,
    output logic [1:0]        memtoregout,
    output logic              regwrout,
    output logic              finout,
    output logic [DWIDTH-1:0] aluoutout,
    output logic [DWIDTH-1:0] memdataout,
    output logic [4:0]        regdstmuxout,
    output logic [AWIDTH-1:0] pcnextout,
    output logic [31:0]       insout
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t            state;
    logic [7:0]        cnt;
    logic              hold_we;
    logic [AWIDTH-1:0] hold_addr;
    logic [DWIDTH-1:0] hold_wdata;

    logic acc;
    logic misal;
    logic tmo_hit;
    logic taken;

    assign acc     = memrdin | memwrin;
    assign misal   = acc & (aluoutin[1:0] != 2'b00);
    assign tmo_hit = (state == S_WAIT) && (cnt == TMO);

    // Memory request: driven live from EX/MEM in IDLE, replayed from the captured copy in WAIT
    always_comb begin
        dmemreq   = 1'b0;
        dmemwe    = memwrin;
        dmemaddr  = AWIDTH'(aluoutin);
        dmemwdata = regdata2in;
        stall     = 1'b0;
        if (state == S_IDLE) begin
            // rstn gating makes the request drop at once when reset hits with an access still presented
            dmemreq = rstn & acc & ~misal;
            stall   = dmemreq & ~dmemack;
        end else begin
            dmemreq   = 1'b1;
            dmemwe    = hold_we;
            dmemaddr  = hold_addr;
            dmemwdata = hold_wdata;
            stall     = ~dmemack & ~tmo_hit;
        end
    end

    // Branch/jump resolution; a stalled instruction never redirects fetch
    always_comb begin
        taken = jumpin
              | (bbeqin  &  zeroin)
              | (bbnein  & ~zeroin)
              | (bblezin & (zeroin | negativein))
              | (bbgtzin & ~zeroin & ~negativein);
        pctarget = jumpin ? jmpaddrin : branaddrin;
        pcsrc    = taken & ~stall;
        flushout = taken & ~stall;
    end

    // Access FSM, timeout counter and sticky error flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            memerr     <= 1'b0;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (misal) begin
                        memerr <= 1'b1;
                    end
                    if (dmemreq && !dmemack) begin
                        // The issue cycle already counts as one cycle of waiting
                        state      <= S_WAIT;
                        cnt        <= 8'd1;
                        hold_we    <= memwrin;
                        hold_addr  <= AWIDTH'(aluoutin);
                        hold_wdata <= regdata2in;
                    end
                end
                S_WAIT: begin
                    if (dmemack) begin
                        state <= S_IDLE;
                        cnt   <= 8'd0;
                    end else if (tmo_hit) begin
                        state  <= S_IDLE;
                        cnt    <= 8'd0;
                        memerr <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    // MEM/WB register: loads the completing instruction, or a bubble while stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            memtoregout  <= 2'b00;
            regwrout     <= 1'b0;
            finout       <= 1'b0;
            aluoutout    <= '0;
            memdataout   <= '0;
            regdstmuxout <= 5'd0;
            pcnextout    <= '0;
            insout       <= 32'd0;
        end else if (stall) begin
            memtoregout  <= 2'b00;
            regwrout     <= 1'b0;
            finout       <= 1'b0;
            aluoutout    <= '0;
            memdataout   <= '0;
            regdstmuxout <= 5'd0;
            pcnextout    <= '0;
            insout       <= 32'd0;
        end else begin
            memtoregout  <= memtoregin;
            regwrout     <= regwrin & ~misal;
            finout       <= finin;
            aluoutout    <= aluoutin;
            // A timed-out load has no ack, so it writes back zero
            memdataout   <= (memrdin && dmemack && !misal) ? dmemrdata : '0;
            regdstmuxout <= regdstmuxin;
            pcnextout    <= pcnextin;
            insout       <= insin;
        end
    end

endmodule

// File: tb/tb_memstage_ctrl.sv
// tb/tb_memstage_ctrl.sv - directed self-checking bench for memstage_ctrl
module tb_memstage_ctrl;

    logic        clk;
    logic        rstn;
    logic        memwrin, memrdin;
    logic        bbnein, bbeqin, bblezin, bbgtzin, jumpin;
    logic [1:0]  memtoregin;
    logic        regwrin, finin;
    logic [31:0] aluoutin;
    logic        zeroin, negativein;
    logic [4:0]  regdstmuxin;
    logic [31:0] regdata2in;
    logic [31:0] branaddrin, jmpaddrin, pcnextin;
    logic [31:0] insin;
    logic        dmemreq, dmemwe;
    logic [31:0] dmemaddr, dmemwdata;
    logic [31:0] dmemrdata;
    logic        dmemack;
    logic        pcsrc;
    logic [31:0] pctarget;
    logic        flushout, stall, memerr;
    logic [1:0]  memtoregout;
    logic        regwrout, finout;
    logic [31:0] aluoutout, memdataout;
    logic [4:0]  regdstmuxout;
    logic [31:0] pcnextout;
    logic [31:0] insout;

    int n_cmp = 0;
    int n_err = 0;

    memstage_ctrl #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn),
        .memwrin(memwrin), .memrdin(memrdin),
        .bbnein(bbnein), .bbeqin(bbeqin), .bblezin(bblezin), .bbgtzin(bbgtzin), .jumpin(jumpin),
        .memtoregin(memtoregin), .regwrin(regwrin), .finin(finin),
        .aluoutin(aluoutin), .zeroin(zeroin), .negativein(negativein),
        .regdstmuxin(regdstmuxin), .regdata2in(regdata2in),
        .branaddrin(branaddrin), .jmpaddrin(jmpaddrin), .pcnextin(pcnextin), .insin(insin),
        .dmemreq(dmemreq), .dmemwe(dmemwe), .dmemaddr(dmemaddr), .dmemwdata(dmemwdata),
        .dmemrdata(dmemrdata), .dmemack(dmemack),
        .pcsrc(pcsrc), .pctarget(pctarget), .flushout(flushout), .stall(stall), .memerr(memerr),
        .memtoregout(memtoregout), .regwrout(regwrout), .finout(finout),
        .aluoutout(aluoutout), .memdataout(memdataout), .regdstmuxout(regdstmuxout),
        .pcnextout(pcnextout), .insout(insout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        memwrin = 0; memrdin = 0;
        bbnein = 0; bbeqin = 0; bblezin = 0; bbgtzin = 0; jumpin = 0;
        memtoregin = 0; regwrin = 0; finin = 0;
        aluoutin = 0; zeroin = 0; negativein = 0;
        regdstmuxin = 0; regdata2in = 0;
        branaddrin = 0; jmpaddrin = 0; pcnextin = 0; insin = 0;
        dmemrdata = 0; dmemack = 0;
    endtask

    initial begin
        clear_inputs();
        rstn = 1'b0;
        #12;
        chk("rst_dmemreq", 32'(dmemreq), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_memerr", 32'(memerr), 32'd0);
        chk("rst_regwrout", 32'(regwrout), 32'd0);
        chk("rst_insout", insout, 32'd0);
        chk("rst_pcsrc", 32'(pcsrc), 32'd0);
        step();
        rstn = 1'b1;

        // Zero-wait load
        step();
        memrdin = 1; aluoutin = 32'h100; dmemack = 1; dmemrdata = 32'hDEADBEEF;
        regwrin = 1; memtoregin = 2'd1; regdstmuxin = 5'd5; insin = 32'h8C000000; pcnextin = 32'h1004;
        #3;
        chk("ld0_dmemreq", 32'(dmemreq), 32'd1);
        chk("ld0_dmemwe", 32'(dmemwe), 32'd0);
        chk("ld0_dmemaddr", dmemaddr, 32'h100);
        chk("ld0_stall", 32'(stall), 32'd0);
        step();
        chk("ld0_memdataout", memdataout, 32'hDEADBEEF);
        chk("ld0_regwrout", 32'(regwrout), 32'd1);
        chk("ld0_insout", insout, 32'h8C000000);
        chk("ld0_regdstmuxout", 32'(regdstmuxout), 32'd5);
        chk("ld0_pcnextout", pcnextout, 32'h1004);
        clear_inputs();

        // Store acknowledged after 3 stalled cycles
        memwrin = 1; aluoutin = 32'h40; regdata2in = 32'h1234; insin = 32'hAC000000; pcnextin = 32'h1008;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk($sformatf("st_stall_%0d", i), 32'(stall), 32'd1);
            chk($sformatf("st_dmemreq_%0d", i), 32'(dmemreq), 32'd1);
            chk($sformatf("st_dmemwe_%0d", i), 32'(dmemwe), 32'd1);
            chk($sformatf("st_dmemaddr_%0d", i), dmemaddr, 32'h40);
            chk($sformatf("st_dmemwdata_%0d", i), dmemwdata, 32'h1234);
            step();
            chk($sformatf("st_bubble_regwr_%0d", i), 32'(regwrout), 32'd0);
            chk($sformatf("st_bubble_ins_%0d", i), insout, 32'd0);
        end
        dmemack = 1;
        #3;
        chk("st_ack_stall", 32'(stall), 32'd0);
        step();
        chk("st_insout", insout, 32'hAC000000);
        chk("st_aluoutout", aluoutout, 32'h40);
        chk("st_memdataout", memdataout, 32'd0);
        clear_inputs();
        #3;
        chk("st_idle_stall", 32'(stall), 32'd0);
        chk("st_idle_dmemreq", 32'(dmemreq), 32'd0);

        // Branch resolution
        step();
        bbeqin = 1; zeroin = 1; branaddrin = 32'h80; jmpaddrin = 32'h200;
        #3;
        chk("beq_taken_pcsrc", 32'(pcsrc), 32'd1);
        chk("beq_taken_flush", 32'(flushout), 32'd1);
        chk("beq_taken_target", pctarget, 32'h80);
        zeroin = 0;
        #1;
        chk("beq_not_pcsrc", 32'(pcsrc), 32'd0);
        chk("beq_not_flush", 32'(flushout), 32'd0);
        jumpin = 1;
        #1;
        chk("jmp_pcsrc", 32'(pcsrc), 32'd1);
        chk("jmp_target", pctarget, 32'h200);
        jumpin = 0; bbeqin = 0; bblezin = 1; negativein = 1;
        #1;
        chk("blez_neg_pcsrc", 32'(pcsrc), 32'd1);
        bblezin = 0; bbgtzin = 1;
        #1;
        chk("bgtz_neg_pcsrc", 32'(pcsrc), 32'd0);
        negativein = 0;
        #1;
        chk("bgtz_pos_pcsrc", 32'(pcsrc), 32'd1);
        bbgtzin = 0; bbnein = 1; zeroin = 1;
        #1;
        chk("bne_zero_pcsrc", 32'(pcsrc), 32'd0);
        step();
        clear_inputs();

        // Misaligned load
        memrdin = 1; aluoutin = 32'h102; regwrin = 1; insin = 32'h8C000002;
        #3;
        chk("mis_dmemreq", 32'(dmemreq), 32'd0);
        chk("mis_stall", 32'(stall), 32'd0);
        step();
        chk("mis_memerr", 32'(memerr), 32'd1);
        chk("mis_regwrout", 32'(regwrout), 32'd0);
        chk("mis_insout", insout, 32'h8C000002);
        clear_inputs();

        // Reset pulse clears the sticky error
        #2;
        rstn = 1'b0;
        #1;
        chk("rst2_memerr", 32'(memerr), 32'd0);
        rstn = 1'b1;

        // Load with no ack times out after 4 stalled cycles
        step();
        memrdin = 1; aluoutin = 32'h200; regwrin = 1; dmemrdata = 32'h55555555; insin = 32'h8C000200;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk($sformatf("tmo_stall_%0d", i), 32'(stall), 32'd1);
            chk($sformatf("tmo_memerr_%0d", i), 32'(memerr), 32'd0);
            step();
        end
        #3;
        chk("tmo_abort_stall", 32'(stall), 32'd0);
        step();
        chk("tmo_memerr", 32'(memerr), 32'd1);
        chk("tmo_memdataout", memdataout, 32'd0);
        chk("tmo_insout", insout, 32'h8C000200);
        clear_inputs();
        #3;
        chk("tmo_idle_stall", 32'(stall), 32'd0);
        chk("tmo_idle_dmemreq", 32'(dmemreq), 32'd0);

        // Asynchronous reset in the middle of a wait
        step();
        memrdin = 1; aluoutin = 32'h300; regwrin = 1;
        step();
        #2;
        chk("rw_wait_stall", 32'(stall), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rw_dmemreq", 32'(dmemreq), 32'd0);
        chk("rw_stall", 32'(stall), 32'd0);
        chk("rw_memerr", 32'(memerr), 32'd0);
        chk("rw_regwrout", 32'(regwrout), 32'd0);
        chk("rw_aluoutout", aluoutout, 32'd0);
        clear_inputs();
        #2;
        rstn = 1'b1;
        step();
        #3;
        chk("rw_after_stall", 32'(stall), 32'd0);
        chk("rw_after_dmemreq", 32'(dmemreq), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memstage_ctrl.md
Name: memstage_ctrl

Overview:
- MEM-stage controller directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM outputs, resolves branches/jumps, and drives a data-memory req/ack handshake.
- Stalls the pipeline while an access is outstanding.
- Contains the MEM/WB register that feeds write-back.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width
TIMEOUT, 255, max cycles waiting for dmemack before abort (8-bit counter)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
memwrin, memrdin  in  1 each  store/load request from EX/MEM
bbnein, bbeqin, bblezin, bbgtzin, jumpin  in  1 each  branch/jump controls
memtoregin  in  2  WB source select
regwrin, finin  in  1 each  WB controls
aluoutin  in  DWIDTH  ALU result / memory address
zeroin, negativein  in  1 each  ALU flags
regdstmuxin  in  5  destination register
regdata2in  in  DWIDTH  store data
branaddrin, jmpaddrin, pcnextin  in  AWIDTH  branch target, jump target, PC+4
insin  in  32  instruction
dmemreq  out  1  memory request
dmemwe  out  1  1 = write
dmemaddr  out  AWIDTH  memory address
dmemwdata  out  DWIDTH  write data
dmemrdata  in  DWIDTH  read data
dmemack  in  1  access complete
pcsrc  out  1  redirect fetch
pctarget  out  AWIDTH  redirect address
flushout  out  1  flush IF/ID, ID/EX, EX/MEM
stall  out  1  freeze PC and upstream registers
memerr  out  1  sticky error (misaligned or timeout)
memtoregout  out  2  MEM/WB register outputs, fields as named
regwrout, finout  out  1 each  MEM/WB register outputs
aluoutout, memdataout  out  DWIDTH  MEM/WB register outputs
regdstmuxout  out  5  MEM/WB register output
pcnextout  out  AWIDTH  MEM/WB register output
insout  out  32  MEM/WB register output

Behaviour:
- Reset (rstn low, async): state IDLE; timeout counter 0; memerr 0; all MEM/WB outputs 0.
  - dmemreq, pcsrc, flushout, stall are 0 combinationally while in IDLE with no access.
- Access definition: acc = memrdin|memwrin. misal = acc & (aluoutin[1:0]!=0).
- FSM states:
  - IDLE, access issue:
    - dmemreq = acc & !misal.
    - dmemwe = memwrin.
    - dmemaddr = aluoutin.
    - dmemwdata = regdata2in.
  - IDLE -> WAIT when dmemreq & !dmemack.
  - Zero-wait: ack in the same cycle completes the access with no stall.
  - WAIT:
    - dmemreq, dmemwe, dmemaddr, dmemwdata held at the same values; upstream is frozen.
    - Counter increments each cycle.
    - WAIT -> IDLE on dmemack.
    - WAIT -> IDLE on counter==TIMEOUT: access aborted, memerr set, memdataout loaded 0.
- Misaligned access: no request issued; memerr set; completes immediately; regwr forced 0 for that instruction.
- stall = (IDLE & dmemreq & !dmemack) | (WAIT & !dmemack & counter!=TIMEOUT).
- Branch resolution (combinational from inputs, only when stall=0):
  - Taken when any of:
    - jumpin
    - bbeqin & zeroin
    - bbnein & !zeroin
    - bblezin & (zeroin|negativein)
    - bbgtzin & !zeroin & !negativein
  - pctarget = jmpaddrin if jumpin, else branaddrin. Jump has priority.
  - pcsrc = flushout = taken & !stall.
- MEM/WB register, posedge clk:
  - stall=0: loads memtoreg, regwr (0 if misal), fin, aluout, regdstmux, pcnext, ins. memdataout = dmemrdata on a read ack, else 0.
  - stall=1: loads a bubble (regwr=0, fin=0, memtoreg=0, ins=0, other fields 0).
- memerr clears only on reset.
- Reset mid-WAIT: returns to IDLE immediately and dmemreq drops. No write completion is guaranteed.

Test Plan:
1. Load, aluoutin=0x100, dmemack same cycle, dmemrdata=0xDEADBEEF -> stall never 1; next edge memdataout=0xDEADBEEF, regwrout=1.
2. Store, aluoutin=0x40, regdata2in=0x1234, ack after 3 cycles -> stall=1 for 3 cycles with dmemaddr/dmemwdata stable; MEM/WB gets 3 bubbles (regwrout=0, insout=0), then the store instruction.
3. bbeqin=1, zeroin=1, branaddrin=0x80 -> pcsrc=flushout=1, pctarget=0x80. Repeat with zeroin=0 -> pcsrc=0. Then jumpin=1 with bbeqin=1 -> pctarget=jmpaddrin.
4. Load, aluoutin=0x102 -> dmemreq=0, memerr=1, regwrout=0 next edge, no stall.
5. Load, no ack, TIMEOUT=4 -> stall for 4 cycles, then state IDLE, memerr=1, memdataout=0.
6. rstn low during WAIT -> dmemreq=0, stall=0, outputs 0 asynchronously; memerr=0.
